// File: rtl/axon_spike_scheduler.sv
// Round-robin spike arbiter feeding a FWFT event FIFO, issuing one spike at a time to synapse_array.
// Optional stats counters are built only when SPIKE_SCHED_STATS_EN is defined.
module axon_spike_scheduler #(
    parameter int unsigned NUM_PORTS  = 4,
    parameter int unsigned NUM_AXONS  = 64,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned ISSUE_GAP  = 2,
    localparam int unsigned AXON_ID_WIDTH = $clog2(NUM_AXONS),
    localparam int unsigned CNT_W         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               enable,
    input  logic                               flush,
    input  logic [NUM_PORTS-1:0]               req_valid,
    input  logic [NUM_PORTS*AXON_ID_WIDTH-1:0] req_axon_id,
    output logic [NUM_PORTS-1:0]               req_ready,
    input  logic                               array_idle,
    output logic                               spike_out_valid,
    output logic [AXON_ID_WIDTH-1:0]           spike_out_axon_id,
    output logic [CNT_W-1:0]                   fifo_count,
    output logic                               sched_busy,
    output logic [31:0]                        issued_count,
    output logic [CNT_W-1:0]                   max_occupancy
);

    localparam int unsigned PTR_W  = $clog2(NUM_PORTS);
    localparam int unsigned ADDR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned GAP_W  = $clog2(ISSUE_GAP + 1);

    typedef enum logic [1:0] {StIdle, StHold, StWait} state_t;

    state_t                   state_q;
    logic [GAP_W-1:0]         gap_q;
    logic [PTR_W-1:0]         rr_q;
    logic [PTR_W-1:0]         grant_idx;
    logic [PTR_W-1:0]         idx;
    logic [AXON_ID_WIDTH-1:0] push_id;
    logic                     push;
    logic                     issue;
    logic [AXON_ID_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [ADDR_W-1:0]        wr_q;
    logic [ADDR_W-1:0]        rd_q;
    logic [CNT_W-1:0]         count_q;
    logic                     fifo_full;
    logic                     fifo_empty;

    assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign fifo_count = count_q;
    assign sched_busy = !((state_q == StIdle) && fifo_empty);
    assign issue      = (state_q == StIdle) && enable && !fifo_empty && array_idle && !flush;

    // Search starts at rr_q; first requester found wins.
    always_comb begin
        req_ready = '0;
        grant_idx = '0;
        idx       = '0;
        push_id   = '0;
        push      = 1'b0;
        if (enable && !fifo_full && !flush) begin
            for (int k = 0; k < int'(NUM_PORTS); k++) begin
                idx = PTR_W'((int'(rr_q) + k) % int'(NUM_PORTS));
                if (!push && req_valid[idx]) begin
                    push           = 1'b1;
                    grant_idx      = idx;
                    req_ready[idx] = 1'b1;
                    push_id        = req_axon_id[idx*AXON_ID_WIDTH +: AXON_ID_WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_q] <= push_id;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            rr_q    <= '0;
        end else if (flush) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_q <= wr_q + 1'b1;
                rr_q <= (grant_idx == PTR_W'(NUM_PORTS - 1)) ? '0 : grant_idx + 1'b1;
            end
            if (issue) begin
                rd_q <= rd_q + 1'b1;
            end
            unique case ({push, issue})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Hold phase masks array_idle while the array is still capturing the issued spike.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q           <= StIdle;
            gap_q             <= '0;
            spike_out_valid   <= 1'b0;
            spike_out_axon_id <= '0;
        end else begin
            spike_out_valid <= 1'b0;
            if (flush) begin
                state_q <= StIdle;
                gap_q   <= '0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (issue) begin
                            spike_out_valid   <= 1'b1;
                            spike_out_axon_id <= mem[rd_q];
                            gap_q             <= GAP_W'(ISSUE_GAP - 1);
                            state_q           <= StHold;
                        end
                    end
                    StHold: begin
                        if (gap_q == '0) begin
                            state_q <= StWait;
                        end else begin
                            gap_q <= gap_q - 1'b1;
                        end
                    end
                    StWait: begin
                        if (array_idle) begin
                            state_q <= StIdle;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

`ifdef SPIKE_SCHED_STATS_EN
    logic [31:0]      issued_q;
    logic [CNT_W-1:0] max_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            issued_q <= '0;
            max_q    <= '0;
        end else begin
            if (spike_out_valid) begin
                issued_q <= issued_q + 32'd1;
            end
            if (count_q > max_q) begin
                max_q <= count_q;
            end
        end
    end

    assign issued_count  = issued_q;
    assign max_occupancy = max_q;
`else
    assign issued_count  = '0;
    assign max_occupancy = '0;
`endif

endmodule

// File: tb/tb_axon_spike_scheduler.sv
// Randomized bench for axon_spike_scheduler against a queue-and-timestamp reference model.
module tb_axon_spike_scheduler;

    localparam int NP    = 4;
    localparam int NA    = 64;
    localparam int DEPTH = 16;
    localparam int GAP   = 2;
    localparam int AW    = 6;
    localparam int CW    = 5;

    logic              clk = 1'b0;
    logic              rst, enable, flush, array_idle;
    logic [NP-1:0]     req_valid, req_ready;
    logic [NP*AW-1:0]  req_axon_id;
    logic              spike_out_valid, sched_busy;
    logic [AW-1:0]     spike_out_axon_id;
    logic [CW-1:0]     fifo_count, max_occupancy;
    logic [31:0]       issued_count;

    axon_spike_scheduler #(
        .NUM_PORTS(NP), .NUM_AXONS(NA), .FIFO_DEPTH(DEPTH), .ISSUE_GAP(GAP)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .flush(flush),
        .req_valid(req_valid), .req_axon_id(req_axon_id), .req_ready(req_ready),
        .array_idle(array_idle), .spike_out_valid(spike_out_valid),
        .spike_out_axon_id(spike_out_axon_id), .fifo_count(fifo_count),
        .sched_busy(sched_busy), .issued_count(issued_count), .max_occupancy(max_occupancy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model: event queue, arbiter pointer, time of last issue.
    logic [AW-1:0] m_q[$];
    int            m_rr = 0;
    bit            m_post = 0;
    int            m_d = 0;
    bit            m_sov = 0;
    logic [AW-1:0] m_id = '0;
    int unsigned   m_issued = 0;
    int            m_max = 0;
    int            arr_timer = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic bit chance(input int pct);
        return $urandom_range(99) < pct;
    endfunction

    task automatic step(input logic r, input logic en, input logic fl, input logic [NP-1:0] v,
                        input logic [NP*AW-1:0] ids, input logic ai);
        logic [NP-1:0] exp_rdy;
        int            g;
        bit            iss;
        rst = r; enable = en; flush = fl; req_valid = v; req_axon_id = ids; array_idle = ai;
        @(negedge clk);
        exp_rdy = '0;
        g = -1;
        if (en && m_q.size() < DEPTH && !fl) begin
            for (int k = 0; k < NP; k++) begin
                if (v[(m_rr + k) % NP]) begin
                    g = (m_rr + k) % NP;
                    exp_rdy[g] = 1'b1;
                    break;
                end
            end
        end
        check("req_ready", 32'(req_ready), 32'(exp_rdy));
        check("fifo_count", 32'(fifo_count), 32'(m_q.size()));
        check("spike_valid", 32'(spike_out_valid), 32'(m_sov));
        check("spike_id", 32'(spike_out_axon_id), 32'(m_id));
        check("busy", 32'(sched_busy), 32'(m_post || m_q.size() > 0));
`ifdef SPIKE_SCHED_STATS_EN
        check("issued", issued_count, m_issued);
        check("max_occ", 32'(max_occupancy), 32'(m_max));
`else
        check("issued", issued_count, 32'd0);
        check("max_occ", 32'(max_occupancy), 32'd0);
`endif
        if (r) begin
            m_q.delete();
            m_rr = 0; m_post = 0; m_sov = 0; m_id = '0; m_issued = 0; m_max = 0;
        end else begin
            m_issued += m_sov;
            if (m_q.size() > m_max) m_max = m_q.size();
            if (fl) begin
                m_q.delete();
                m_post = 0;
                m_sov  = 0;
            end else begin
                iss = !m_post && en && m_q.size() > 0 && ai;
                // Array idle is only honoured once the capture gap after an issue has elapsed.
                if (m_post && cyc > m_d + GAP && ai) m_post = 0;
                m_sov = iss;
                if (iss) begin
                    m_id   = m_q.pop_front();
                    m_post = 1;
                    m_d    = cyc;
                end
                if (g >= 0) begin
                    m_q.push_back(ids[g*AW +: AW]);
                    m_rr = (g + 1) % NP;
                end
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NP*AW-1:0] rand_ids();
        logic [NP*AW-1:0] x;
        for (int i = 0; i < NP; i++) x[i*AW +: AW] = AW'($urandom_range(NA - 1));
        return x;
    endfunction

    // Stimulus segment; mode 1 lets a simple array model drop idle for hold cycles after each issue.
    task automatic run_seg(input int ncyc, input int p_valid, input int p_idle, input int p_en,
                           input int p_flush, input int p_rst, input int mode, input int hold);
        logic ai;
        bit   seen;
        for (int i = 0; i < ncyc; i++) begin
            ai   = (mode == 1) ? (arr_timer == 0) : chance(p_idle);
            seen = m_sov;
            step(chance(p_rst), chance(p_en), chance(p_flush),
                 {chance(p_valid), chance(p_valid), chance(p_valid), chance(p_valid)},
                 rand_ids(), ai);
            if (seen) arr_timer = hold;
            else if (arr_timer > 0) arr_timer--;
        end
    endtask

    initial begin
        logic [NP*AW-1:0] ids;
        rst = 1'b1; enable = 1'b0; flush = 1'b0; req_valid = '0; req_axon_id = '0;
        array_idle = 1'b1;
        @(posedge clk);
        #1;
        step(1'b1, 1'b0, 1'b0, 4'b0000, '0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 4'b0000, '0, 1'b1);
        // Single request on port 2, then quiet so the issue latency is visible.
        ids = '0;
        ids[2*AW +: AW] = 6'h15;
        step(1'b0, 1'b1, 1'b0, 4'b0100, ids, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, 4'b0000, '0, 1'b1);
        // All ports valid with ids 1..4 and the array held busy: round robin then backpressure.
        ids = {6'd4, 6'd3, 6'd2, 6'd1};
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b0, 4'b1111, ids, 1'b0);
        for (int i = 0; i < 80; i++) step(1'b0, 1'b1, 1'b0, 4'b0000, '0, 1'b1);
        // Flush with entries queued while a push is offered, then push right after.
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 4'b0001, rand_ids(), 1'b0);
        step(1'b0, 1'b1, 1'b1, 4'b0011, rand_ids(), 1'b1);
        step(1'b0, 1'b1, 1'b0, 4'b0010, rand_ids(), 1'b1);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1'b0, 4'b0000, '0, 1'b1);
        run_seg(500, 30, 80, 95, 1, 0, 0, 0);
        run_seg(300, 60, 70, 100, 0, 0, 1, 3);
        run_seg(700, 20, 0, 100, 0, 0, 1, 130);
        run_seg(600, 50, 50, 70, 5, 0, 0, 0);
        run_seg(600, 40, 60, 90, 2, 1, 0, 0);
        run_seg(400, 25, 0, 100, 0, 0, 1, 5);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
